// File: rtl/muldiv_issue_ctrl_pkg.sv
// muldiv_issue_ctrl_pkg: shared op encodings, FSM states and request bundle for the M-unit issue controller
package muldiv_issue_ctrl_pkg;
    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'd0,
        MULDIV_MULH   = 3'd1,
        MULDIV_MULHSU = 3'd2,
        MULDIV_MULHU  = 3'd3,
        MULDIV_DIV    = 3'd4,
        MULDIV_DIVU   = 3'd5,
        MULDIV_REM    = 3'd6,
        MULDIV_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {MDC_IDLE, MDC_ISSUE, MDC_WAIT, MDC_WB} mdc_state_e;

    typedef struct packed {
        muldiv_op_e  op;
        logic [31:0] a;
        logic [31:0] b;
    } md_req_t;
endpackage

// File: rtl/muldiv_issue_ctrl_if.sv
// muldiv_issue_ctrl_if: start/op/operand/result handshake between the issue controller and the multiply/divide unit
interface muldiv_issue_ctrl_if;
    import muldiv_issue_ctrl_pkg::*;
    logic        md_start;
    muldiv_op_e  md_op;
    logic [31:0] md_operand_a;
    logic [31:0] md_operand_b;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_result;
    modport master (output md_start, md_op, md_operand_a, md_operand_b, input md_busy, md_done, md_result);
    modport slave (input md_start, md_op, md_operand_a, md_operand_b, output md_busy, md_done, md_result);
endinterface

// File: rtl/muldiv_issue_ctrl_memo.sv
// muldiv_memo: single-entry cache of the last completed op/operands/result with an exact-match hit check
module muldiv_memo
    import muldiv_issue_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        upd_i,
    input  md_req_t     upd_req_i,
    input  logic [31:0] upd_result_i,
    input  md_req_t     look_req_i,
    output logic        hit_o,
    output logic [31:0] result_o
);
    logic        valid_q;
    md_req_t     req_q;
    logic [31:0] result_q;

    // Remember the most recent operation the unit completed; only reset clears it
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q  <= 1'b0;
            req_q    <= '0;
            result_q <= '0;
        end else if (upd_i) begin
            valid_q  <= 1'b1;
            req_q    <= upd_req_i;
            result_q <= upd_result_i;
        end
    end

    assign hit_o    = valid_q && (req_q == look_req_i);
    assign result_o = result_q;
endmodule

// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: EX-stage issue/stall/writeback sequencer for the RV32M multi-cycle unit
module muldiv_issue_ctrl
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter bit MEMO_EN        = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                ex_valid_i,
    input  logic                ex_is_muldiv_i,
    input  logic [2:0]          ex_op_i,
    input  logic [31:0]         ex_rs1_i,
    input  logic [31:0]         ex_rs2_i,
    input  logic [4:0]          ex_rd_i,
    input  logic                flush_i,
    output logic                stall_o,
    muldiv_issue_ctrl_if.master md,
    output logic                wb_valid_o,
    output logic [4:0]          wb_rd_o,
    output logic [31:0]         wb_data_o,
    output logic                timeout_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    mdc_state_e  state_q, state_d;
    md_req_t     req_q, req_d, ex_req;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d, memo_result;
    logic        kill_q, kill_d, timeout_q, timeout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        req, hit, expire, memo_upd, in_flight;

    assign req       = ex_valid_i & ex_is_muldiv_i & ~flush_i;
    assign ex_req    = '{op: muldiv_op_e'(ex_op_i), a: ex_rs1_i, b: ex_rs2_i};
    assign in_flight = (state_q == MDC_ISSUE) || (state_q == MDC_WAIT);
    assign memo_upd  = (state_q == MDC_WAIT) && md.md_done;
    assign expire    = cnt_d == CW'(TIMEOUT_CYCLES);

    if (MEMO_EN) begin : g_memo
        muldiv_memo u_memo (
            .clk_i        (clk_i),
            .rst_n_i      (rst_n_i),
            .upd_i        (memo_upd),
            .upd_req_i    (req_q),
            .upd_result_i (md.md_result),
            .look_req_i   (ex_req),
            .hit_o        (hit),
            .result_o     (memo_result)
        );
    end else begin : g_no_memo
        assign hit         = 1'b0;
        assign memo_result = '0;
    end

    // State and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= MDC_IDLE;
            req_q     <= '0;
            rd_q      <= '0;
            data_q    <= '0;
            kill_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            kill_q    <= kill_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state: a killed op still drains the unit but skips writeback
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDC_IDLE:  if (req) state_d = hit ? MDC_WB : MDC_ISSUE;
            MDC_ISSUE: if (md.md_start) state_d = MDC_WAIT;
            MDC_WAIT:  if (md.md_done || expire) state_d = kill_d ? MDC_IDLE : MDC_WB;
            default:   state_d = MDC_IDLE;
        endcase
    end

    // Datapath next values: capture on accept, result on done, zero on watchdog expiry
    always_comb begin
        req_d     = (state_q == MDC_IDLE && req) ? ex_req : req_q;
        rd_d      = (state_q == MDC_IDLE && req) ? ex_rd_i : rd_q;
        kill_d    = in_flight & (kill_q | flush_i);
        cnt_d     = (state_q == MDC_WAIT) ? cnt_q + 1'b1 : '0;
        data_d    = (state_q == MDC_IDLE && req && hit) ? memo_result :
                    memo_upd ? md.md_result :
                    (state_q == MDC_WAIT && expire) ? 32'd0 : data_q;
        timeout_d = timeout_q | (state_q == MDC_WAIT && !md.md_done && expire);
    end

    // Outputs: stall while the op is outstanding, except killed ops only hold back M instructions
    always_comb begin
        md.md_start = (state_q == MDC_ISSUE) & ~md.md_busy & ~md.md_done;
        stall_o     = (state_q == MDC_IDLE) ? req :
                      (state_q == MDC_WB) ? 1'b0 :
                      kill_q ? (ex_valid_i & ex_is_muldiv_i) : 1'b1;
        wb_valid_o  = (state_q == MDC_WB) & ~flush_i;
    end

    assign md.md_op        = req_q.op;
    assign md.md_operand_a = req_q.a;
    assign md.md_operand_b = req_q.b;
    assign wb_rd_o         = rd_q;
    assign wb_data_o       = data_q;
    assign timeout_o       = timeout_q;
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb_muldiv_issue_ctrl: scoreboard bench with a behavioural RV32M unit stub and a memo reference model
module tb_muldiv_issue_ctrl;
    import muldiv_issue_ctrl_pkg::*;

    logic        clk_i = 1'b0, rst_n_i = 1'b0;
    logic        ex_valid_i = 1'b0, ex_is_muldiv_i = 1'b0, flush_i = 1'b0;
    logic [2:0]  ex_op_i = '0;
    logic [31:0] ex_rs1_i = '0, ex_rs2_i = '0;
    logic [4:0]  ex_rd_i = '0;
    logic        stall_o, wb_valid_o, timeout_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    muldiv_issue_ctrl_if mdif();

    muldiv_issue_ctrl #(.TIMEOUT_CYCLES(8), .MEMO_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ex_valid_i(ex_valid_i), .ex_is_muldiv_i(ex_is_muldiv_i),
        .ex_op_i(ex_op_i), .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i), .ex_rd_i(ex_rd_i),
        .flush_i(flush_i), .stall_o(stall_o), .md(mdif), .wb_valid_o(wb_valid_o),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0, checks = 0, cyc = 0, n_start = 0, t_start = 0, t_wb = 0;
    logic [36:0] exp_q[$];
    bit memo_v = 1'b0;
    logic [2:0] memo_op;
    logic [31:0] memo_a, memo_b;
    bit ext_busy = 1'b0, ext_done = 1'b0, no_done = 1'b0;
    int u_left;
    logic [31:0] u_res;

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (op == 3'd0) return a * b;
        if (op == 3'd1) begin p = sa * sb; return p[63:32]; end
        if (op == 3'd2) begin p = sa * $signed({32'd0, b}); return p[63:32]; end
        if (op == 3'd3) begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
        if (op == 3'd4) return (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'($signed(a) / $signed(b));
        if (op == 3'd5) return (b == 0) ? 32'hFFFF_FFFF : a / b;
        if (op == 3'd6) return (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'($signed(a) % $signed(b));
        return (b == 0) ? a : a % b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Unit stub: busy the cycle after start, done with the result the cycle after that
    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            u_left <= 0;
            u_res  <= '0;
        end else if (mdif.md_start && !no_done) begin
            u_left <= 2;
            u_res  <= ref_md(mdif.md_op, mdif.md_operand_a, mdif.md_operand_b);
        end else if (u_left > 0) begin
            u_left <= u_left - 1;
        end
    end
    assign mdif.md_busy   = ext_busy | (u_left == 2);
    assign mdif.md_done   = ext_done | (u_left == 1);
    assign mdif.md_result = u_res;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: count start pulses, pop and compare every writeback
    initial forever begin
        logic [36:0] e;
        @(negedge clk_i);
        #1;
        if (rst_n_i && mdif.md_start) begin
            n_start++;
            t_start = cyc;
        end
        if (rst_n_i && wb_valid_o) begin
            t_wb = cyc;
            if (exp_q.size() == 0) chk("wb_unexpected", {27'd0, wb_rd_o, wb_data_o}, 64'h0);
            else begin
                e = exp_q.pop_front();
                chk("wb_rd_data", {27'd0, wb_rd_o, wb_data_o}, {27'd0, e});
            end
        end
    end

    task automatic rst_check(input string name);
        chk({name, "_ctrl"}, {56'd0, stall_o, mdif.md_start, wb_valid_o, timeout_o, 1'b0, mdif.md_op}, 64'd0);
        chk({name, "_operands"}, {mdif.md_operand_a, mdif.md_operand_b}, 64'd0);
        chk({name, "_wb"}, {27'd0, wb_rd_o, wb_data_o}, 64'd0);
    endtask

    // Present one M instruction, hold it until it retires, then check timing against the model
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int busy, input int pre);
        bit hit;
        int lat, stalls, s0, t_acc;
        hit = memo_v && memo_op == op && memo_a == a && memo_b == b;
        lat = pre + (hit ? 1 : (no_done ? 10 : 4) + busy);
        exp_q.push_back({rd, (no_done && !hit) ? 32'd0 : ref_md(op, a, b)});
        s0 = n_start;
        @(negedge clk_i);
        flush_i = 1'b0; ex_valid_i = 1'b1; ex_is_muldiv_i = 1'b1;
        ex_op_i = op; ex_rs1_i = a; ex_rs2_i = b; ex_rd_i = rd;
        t_acc = cyc;
        if (busy > 0 && !hit) begin
            ext_busy = 1'b1;
            fork
                begin
                    repeat (busy + 1) @(negedge clk_i);
                    ext_busy = 1'b0;
                end
            join_none
        end
        #1;
        stalls = 0;
        while (stall_o && stalls < 100) begin
            stalls++;
            @(negedge clk_i);
            #1;
        end
        @(negedge clk_i);
        ex_valid_i = 1'b0; ex_is_muldiv_i = 1'b0;
        #2;
        chk("stall_cycles", 64'(stalls), 64'(lat));
        chk("wb_latency", 64'(t_wb - t_acc), 64'(lat));
        chk("start_count", 64'(n_start - s0), hit ? 64'd0 : 64'd1);
        if (!hit) chk("start_latency", 64'(t_start - t_acc), 64'(pre + 1 + busy));
        if (!hit && !no_done) begin
            memo_v = 1'b1; memo_op = op; memo_a = a; memo_b = b;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pool [4];
        logic [2:0] l_op, r_op;
        logic [31:0] l_a, l_b, r_a, r_b;
        pool = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd13};
        repeat (3) @(negedge clk_i);
        #1;
        rst_check("reset");
        rst_n_i = 1'b1;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, 0);
        chk("mul_neg_result", {32'd0, wb_data_o}, 64'hFFFF_FFEB);
        issue(3'd5, 32'd100, 32'd7, 5'd6, 0, 0);
        issue(3'd5, 32'd100, 32'd7, 5'd7, 0, 0);
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8, 5, 0);

        @(negedge clk_i);
        ex_valid_i = 1'b1; ex_is_muldiv_i = 1'b1; ex_op_i = 3'd7;
        ex_rs1_i = 32'd10; ex_rs2_i = 32'd3; ex_rd_i = 5'd10;
        @(negedge clk_i);
        @(negedge clk_i);
        ex_valid_i = 1'b0; ex_is_muldiv_i = 1'b0; flush_i = 1'b1;
        memo_v = 1'b1; memo_op = 3'd7; memo_a = 32'd10; memo_b = 32'd3;
        issue(3'd0, 32'd0, 32'd12345, 5'd11, 0, 1);
        chk("mul_zero_result", {32'd0, wb_data_o}, 64'd0);

        no_done = 1'b1;
        issue(3'd3, 32'd55, 32'd66, 5'd12, 0, 0);
        no_done = 1'b0;
        chk("timeout_set", {63'd0, timeout_o}, 64'd1);
        @(negedge clk_i);
        ext_done = 1'b1;
        @(negedge clk_i);
        ext_done = 1'b0;
        #1;
        chk("spurious_done_wb", {62'd0, wb_valid_o, stall_o}, 64'd0);
        issue(3'd6, 32'hFFFF_FFCE, 32'd7, 5'd9, 0, 0);
        chk("timeout_sticky", {63'd0, timeout_o}, 64'd1);

        @(negedge clk_i);
        ex_valid_i = 1'b1; ex_is_muldiv_i = 1'b1; ex_op_i = 3'd4;
        ex_rs1_i = 32'd1000; ex_rs2_i = 32'd3; ex_rd_i = 5'd13;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b0; ex_valid_i = 1'b0; ex_is_muldiv_i = 1'b0;
        #1;
        rst_check("midop_reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        memo_v = 1'b0;
        issue(3'd6, 32'hFFFF_FFCE, 32'd7, 5'd9, 0, 0);

        l_op = 3'd0; l_a = 32'd1; l_b = 32'd1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                r_op = l_op; r_a = l_a; r_b = l_b;
            end else begin
                r_op = 3'($urandom_range(0, 7));
                r_a  = ($urandom_range(0, 2) == 0) ? $urandom : pool[$urandom_range(0, 3)];
                r_b  = ($urandom_range(0, 2) == 0) ? $urandom : pool[$urandom_range(0, 3)];
            end
            issue(r_op, r_a, r_b, 5'($urandom), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0, 0);
            l_op = r_op; l_a = r_a; l_b = r_b;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
